// File: rtl/b_resolve_reporter.sv
// b_resolve_reporter
// Branch-resolution back end: counts consecutive correct predictions, turns
// each mispredict/flush into a 42-bit correction message, queues it, and
// delivers it to the fetch side over a 2-phase drive/free toggle handshake.
//
// Handshake semantics:
//   * Resolution input: a resolution transfers on a rising clk edge where
//     i_res_valid & o_res_ready are both 1. o_res_ready depends only on
//     registered queue occupancy (1 whenever the queue is not full).
//   * Fetch output: a new message is offered by toggling o_drive, with
//     o_data_42 updated on the same edge and held until the next offer.
//     The fetch side consumes it by making i_free equal to o_drive. i_free
//     is asynchronous and is only used after a 2-flop synchronizer.
module b_resolve_reporter #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_res_valid,
   output logic        o_res_ready,
   input  logic        i_res_mispredict,
   input  logic        i_res_flush,
   input  logic [2:0]  i_res_slot_3,
   input  logic [31:0] i_res_correctPc_32,
   output logic        o_drive,
   input  logic        i_free,
   output logic [41:0] o_data_42,
   output logic [2:0]  o_queued_3,
   output logic        o_dbg_state
);

   localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   // Queue storage and wrap-around pointers (extra MSB tells full from empty)
   logic [41:0] r_mem [FIFO_DEPTH];
   logic [PW:0] r_wr_ptr;
   logic [PW:0] r_rd_ptr;
   logic [PW:0] w_count;
   logic [31:0] w_count_ext;
   logic        w_full;
   logic        w_empty;

   // Resolution side
   logic        w_accept;
   logic        w_enq;
   logic [7:0]  w_errpos;
   logic [41:0] w_msg;
   logic [2:0]  r_cnt;
   logic        w_unused_pc;

   // Transmit side
   logic        r_free_s1;
   logic        r_free_s2;
   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_send;
   logic        w_pop;
   logic        w_acked;
   logic        r_drive;
   logic [41:0] r_data;

   assign w_count     = r_wr_ptr - r_rd_ptr;
   assign w_count_ext = {{(31 - PW){1'b0}}, w_count};
   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                        (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

   // A correct resolution also waits on a full queue so it can never
   // overtake a correction that is still waiting to be queued.
   assign o_res_ready = ~w_full;
   assign w_accept    = i_res_valid & ~w_full;
   assign w_enq       = w_accept & (i_res_mispredict | i_res_flush);

   // Mispredict wins over flush; a flush carries no error position.
   assign w_errpos    = i_res_mispredict ? (8'h01 << i_res_slot_3) : 8'h00;
   assign w_msg       = {i_res_mispredict, w_errpos, r_cnt, i_res_correctPc_32[31:2]};

   // Instruction-aligned PCs: the low two bits are never transmitted.
   assign w_unused_pc = ^i_res_correctPc_32[1:0];

   assign o_queued_3  = (w_count_ext > 32'd7) ? 3'd7 : w_count_ext[2:0];
   assign o_drive     = r_drive;
   assign o_data_42   = r_data;
   assign o_dbg_state = r_state;

   // Saturating run length of correct predictions, cleared by each correction
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= 3'd0;
      end else if (w_accept) begin
         if (i_res_mispredict | i_res_flush) begin
            r_cnt <= 3'd0;
         end else if (r_cnt != 3'd7) begin
            r_cnt <= r_cnt + 3'd1;
         end
      end
   end

   // Message storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem[r_wr_ptr[PW-1:0]] <= w_msg;
      end
   end

   // Queue pointers; enqueue and pop in the same cycle are both honoured
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // Two-flop synchronizer for the asynchronous acknowledge toggle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_free_s1 <= 1'b0;
         r_free_s2 <= 1'b0;
      end else begin
         r_free_s1 <= i_free;
         r_free_s2 <= r_free_s1;
      end
   end

   // Transmit FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Transmit FSM next state: offer the head, then wait for its acknowledge
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (!w_empty) w_state_nxt = S_WAIT;
         S_WAIT:  if (w_acked)  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Transmit FSM outputs: send strobe in IDLE, pop strobe on acknowledge
   always_comb begin
      w_acked = (r_free_s2 == r_drive);
      w_send  = 1'b0;
      w_pop   = 1'b0;
      case (r_state)
         S_IDLE:  w_send = ~w_empty;
         S_WAIT:  w_pop  = w_acked;
         default: begin
            w_send = 1'b0;
            w_pop  = 1'b0;
         end
      endcase
   end

   // Request toggle and message register, updated together on each send
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_drive <= 1'b0;
         r_data  <= 42'd0;
      end else if (w_send) begin
         r_drive <= ~r_drive;
         r_data  <= r_mem[r_rd_ptr[PW-1:0]];
      end
   end

endmodule

// File: tb/tb_b_resolve_reporter.sv
// Testbench for b_resolve_reporter: resolution driver, fetch-side ack model,
// a send monitor that pops an expected-message queue on every o_drive toggle,
// and one task per scenario.
module tb_b_resolve_reporter;

   logic        clk;
   logic        rst;
   logic        i_res_valid;
   logic        o_res_ready;
   logic        i_res_mispredict;
   logic        i_res_flush;
   logic [2:0]  i_res_slot_3;
   logic [31:0] i_res_correctPc_32;
   logic        o_drive;
   logic        i_free;
   logic [41:0] o_data_42;
   logic [2:0]  o_queued_3;
   logic        o_dbg_state;

   int          cyc = 0;
   int          chk_cnt = 0;
   int          pass_cnt = 0;
   logic [41:0] exp_q[$];
   int          tog_cyc[$];
   int          pop_cyc = -1;
   int          free_cyc = -1;
   logic [41:0] last_data = 42'd0;
   bit          ack_hold = 1'b0;
   int          ack_delay = 5;
   int          fdly = 0;
   logic [2:0]  tb_cnt = 3'd0;
   logic        prev_drive = 1'b0;
   logic [2:0]  prev_q = 3'd0;

   b_resolve_reporter #(.FIFO_DEPTH(4)) dut (
      .clk                (clk),
      .rst                (rst),
      .i_res_valid        (i_res_valid),
      .o_res_ready        (o_res_ready),
      .i_res_mispredict   (i_res_mispredict),
      .i_res_flush        (i_res_flush),
      .i_res_slot_3       (i_res_slot_3),
      .i_res_correctPc_32 (i_res_correctPc_32),
      .o_drive            (o_drive),
      .i_free             (i_free),
      .o_data_42          (o_data_42),
      .o_queued_3         (o_queued_3),
      .o_dbg_state        (o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   function automatic logic [41:0] mk_msg(input logic mp, input logic [2:0] slot,
                                          input logic [2:0] cnt, input logic [31:0] pc);
      logic [7:0] e;
      e = 8'h00;
      if (mp) e[slot] = 1'b1;
      return {mp, e, cnt, pc[31:2]};
   endfunction

   // ---------------- fetch-side ack model ----------------
   initial begin
      i_free = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            i_free = 1'b0;
            fdly = 0;
         end else if (ack_hold) begin
            fdly = 0;
         end else if (i_free !== o_drive) begin
            if (fdly >= ack_delay) begin
               i_free = o_drive;
               fdly = 0;
               free_cyc = cyc;
            end else begin
               fdly++;
            end
         end
      end
   end

   // ---------------- send monitor / scoreboard ----------------
   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
         prev_drive = 1'b0;
         prev_q = 3'd0;
      end else begin
         if (o_drive !== prev_drive) begin
            tog_cyc.push_back(cyc);
            last_data = o_data_42;
            chk_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_unexpected_send: got data=%h with no message expected (cyc %0d)", o_data_42, cyc);
            end else begin
               logic [41:0] exp;
               exp = exp_q.pop_front();
               if (o_data_42 !== exp)
                  $display("FAIL sb_data: got %h expected %h (cyc %0d)", o_data_42, exp, cyc);
               else
                  pass_cnt++;
            end
            prev_drive = o_drive;
         end
         if (o_queued_3 < prev_q) pop_cyc = cyc;
         prev_q = o_queued_3;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      ack_hold = 1'b0;
      exp_q.delete();
      tb_cnt = 3'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic send_res(input logic mp, input logic fl, input logic [2:0] slot,
                           input logic [31:0] pc, output int acc_cyc);
      bit   done;
      int   n;
      logic rdy;
      done = 1'b0;
      n = 0;
      acc_cyc = -1;
      @(negedge clk);
      i_res_valid = 1'b1;
      i_res_mispredict = mp;
      i_res_flush = fl;
      i_res_slot_3 = slot;
      i_res_correctPc_32 = pc;
      while (!done) begin
         rdy = o_res_ready;
         @(posedge clk);
         #2;
         if (rdy) begin
            done = 1'b1;
            acc_cyc = cyc;
            if (mp | fl) begin
               exp_q.push_back(mk_msg(mp, slot, tb_cnt, pc));
               tb_cnt = 3'd0;
            end else if (tb_cnt != 3'd7) begin
               tb_cnt = tb_cnt + 3'd1;
            end
         end else begin
            n++;
            if (n > 200) begin
               chk_cnt++;
               $display("FAIL accept_timeout: resolution not accepted, ready=%b required 1", o_res_ready);
               done = 1'b1;
            end else begin
               @(negedge clk);
            end
         end
      end
      #1;
      i_res_valid = 1'b0;
   endtask

   task automatic wait_toggles(input int target, input int budget);
      int n;
      n = 0;
      while (tog_cyc.size() < target && n < budget) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (tog_cyc.size() < target) begin
         chk_cnt++;
         $display("FAIL toggle_timeout: got %0d sends required %0d", tog_cyc.size(), target);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (o_queued_3 != 3'd0 && n < 300) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (o_queued_3 != 3'd0) begin
         chk_cnt++;
         $display("FAIL drain_timeout: queued=%0d required 0", o_queued_3);
      end
      repeat (2) @(posedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #2;
      chk_cnt++; if (o_drive !== 1'b0) $display("FAIL rst_drive: got %b required 0", o_drive); else pass_cnt++;
      chk_cnt++; if (o_data_42 !== 42'd0) $display("FAIL rst_data: got %h required 0", o_data_42); else pass_cnt++;
      chk_cnt++; if (o_res_ready !== 1'b1) $display("FAIL rst_ready: got %b required 1", o_res_ready); else pass_cnt++;
      chk_cnt++; if (o_queued_3 !== 3'd0) $display("FAIL rst_queued: got %0d required 0", o_queued_3); else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_counter();
      int acc;
      int n0;
      ack_delay = 5;
      for (int i = 0; i < 9; i++)
         send_res(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, acc);
      n0 = tog_cyc.size();
      send_res(1'b1, 1'b0, 3'd3, 32'h0000_1040, acc);
      @(posedge clk);
      #2;
      chk_cnt++;
      if (tog_cyc.size() != n0 + 1 || tog_cyc[tog_cyc.size()-1] != acc + 1)
         $display("FAIL cnt_latency: sends=%0d (required %0d) at cyc %0d required %0d", tog_cyc.size(), n0 + 1, cyc, acc + 1);
      else pass_cnt++;
      chk_cnt++;
      if (o_data_42 !== {1'b1, 8'h08, 3'd7, 30'h0000_0410})
         $display("FAIL cnt_msg: got %h required %h", o_data_42, {1'b1, 8'h08, 3'd7, 30'h0000_0410});
      else pass_cnt++;
      chk_cnt++; if (o_drive !== 1'b1) $display("FAIL cnt_drive: got %b required 1", o_drive); else pass_cnt++;
      wait_drain();
   endtask

   task automatic test_flush();
      int acc;
      int n0;
      send_res(1'b0, 1'b0, 3'd0, 32'h0000_0010, acc);
      send_res(1'b0, 1'b0, 3'd1, 32'h0000_0020, acc);
      n0 = tog_cyc.size();
      send_res(1'b0, 1'b1, 3'd6, 32'h8000_0004, acc);
      send_res(1'b1, 1'b0, 3'd5, 32'h0000_0100, acc);
      wait_toggles(n0 + 1, 20);
      chk_cnt++;
      if (last_data !== {1'b0, 8'h00, 3'd2, 30'h2000_0001})
         $display("FAIL flush_msg: got %h required %h", last_data, {1'b0, 8'h00, 3'd2, 30'h2000_0001});
      else pass_cnt++;
      wait_toggles(n0 + 2, 60);
      chk_cnt++;
      if (last_data !== {1'b1, 8'h20, 3'd0, 30'h0000_0040})
         $display("FAIL flush_next_msg: got %h required %h", last_data, {1'b1, 8'h20, 3'd0, 30'h0000_0040});
      else pass_cnt++;
      wait_drain();
   endtask

   task automatic test_handshake();
      int a1;
      int a2;
      int n0;
      apply_reset();
      ack_delay = 5;
      n0 = tog_cyc.size();
      send_res(1'b1, 1'b0, 3'd1, 32'h0000_2000, a1);
      send_res(1'b1, 1'b0, 3'd2, 32'h0000_3000, a2);
      wait_toggles(n0 + 2, 100);
      if (tog_cyc.size() >= n0 + 2) begin
         chk_cnt++;
         if (tog_cyc[n0] != a1 + 1) $display("FAIL hs_first_send: at cyc %0d required %0d", tog_cyc[n0], a1 + 1); else pass_cnt++;
         chk_cnt++;
         if (pop_cyc - free_cyc < 2 || pop_cyc - free_cyc > 3)
            $display("FAIL hs_pop_delay: pop %0d edges after free toggle, required 2..3", pop_cyc - free_cyc);
         else pass_cnt++;
         chk_cnt++;
         if (tog_cyc[n0+1] != pop_cyc + 1) $display("FAIL hs_second_send: at cyc %0d required %0d", tog_cyc[n0+1], pop_cyc + 1); else pass_cnt++;
         chk_cnt++;
         if (o_drive !== 1'b0) $display("FAIL hs_drive: got %b required 0", o_drive); else pass_cnt++;
      end
      wait_drain();
   endtask

   task automatic test_full();
      int a;
      int a5;
      apply_reset();
      ack_hold = 1'b1;
      for (int i = 0; i < 4; i++)
         send_res(1'b1, 1'b0, 3'(i), 32'h0001_0000 + 32'(i * 16), a);
      @(negedge clk);
      chk_cnt++; if (o_res_ready !== 1'b0) $display("FAIL full_ready: got %b required 0", o_res_ready); else pass_cnt++;
      chk_cnt++; if (o_queued_3 !== 3'd4) $display("FAIL full_queued: got %0d required 4", o_queued_3); else pass_cnt++;
      fork
         send_res(1'b1, 1'b0, 3'd4, 32'h0001_0040, a5);
         begin
            repeat (3) @(negedge clk);
            chk_cnt++;
            if (o_res_ready !== 1'b0 || o_queued_3 !== 3'd4)
               $display("FAIL full_held: ready=%b queued=%0d required 0/4", o_res_ready, o_queued_3);
            else pass_cnt++;
            ack_delay = 2;
            ack_hold = 1'b0;
         end
      join
      chk_cnt++;
      if (a5 != pop_cyc + 1) $display("FAIL full_fifth_accept: at cyc %0d required %0d", a5, pop_cyc + 1); else pass_cnt++;
      wait_drain();
   endtask

   task automatic test_priority();
      int acc;
      int n0;
      logic [2:0] c;
      c = tb_cnt;
      n0 = tog_cyc.size();
      send_res(1'b1, 1'b1, 3'd6, 32'h0000_2008, acc);
      wait_toggles(n0 + 1, 20);
      chk_cnt++; if (last_data[41] !== 1'b1) $display("FAIL prio_type: got %b required 1", last_data[41]); else pass_cnt++;
      chk_cnt++;
      if (last_data !== {1'b1, 8'h40, c, 30'h0000_0802})
         $display("FAIL prio_msg: got %h required %h", last_data, {1'b1, 8'h40, c, 30'h0000_0802});
      else pass_cnt++;
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int a1;
      int a2;
      int a3;
      int n0;
      apply_reset();
      ack_delay = 0;
      n0 = tog_cyc.size();
      send_res(1'b1, 1'b0, 3'd7, 32'h0000_4000, a1);
      send_res(1'b0, 1'b1, 3'd0, 32'h0000_5000, a2);
      send_res(1'b1, 1'b0, 3'd2, 32'h0000_6000, a3);
      chk_cnt++;
      if (a2 != a1 + 1 || a3 != a2 + 1) $display("FAIL b2b_accept: cycles %0d %0d %0d required consecutive", a1, a2, a3); else pass_cnt++;
      wait_toggles(n0 + 3, 60);
      if (tog_cyc.size() >= n0 + 3) begin
         chk_cnt++;
         if (tog_cyc[n0+1] - tog_cyc[n0] != 4) $display("FAIL b2b_gap1: got %0d cycles required 4", tog_cyc[n0+1] - tog_cyc[n0]); else pass_cnt++;
         chk_cnt++;
         if (tog_cyc[n0+2] - tog_cyc[n0+1] != 4) $display("FAIL b2b_gap2: got %0d cycles required 4", tog_cyc[n0+2] - tog_cyc[n0+1]); else pass_cnt++;
      end
      wait_drain();
   endtask

   task automatic test_reset_mid();
      int acc;
      int n0;
      apply_reset();
      ack_hold = 1'b1;
      for (int i = 0; i < 3; i++)
         send_res(1'b1, 1'b0, 3'(i + 1), 32'h0002_0000 + 32'(i * 4), acc);
      repeat (2) @(posedge clk);
      #2;
      chk_cnt++;
      if (o_queued_3 !== 3'd3 || o_drive !== 1'b1 || o_dbg_state !== 1'b1)
         $display("FAIL midrst_pre: queued=%0d drive=%b state=%b required 3/1/1", o_queued_3, o_drive, o_dbg_state);
      else pass_cnt++;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk_cnt++; if (o_drive !== 1'b0) $display("FAIL midrst_drive: got %b required 0", o_drive); else pass_cnt++;
      chk_cnt++; if (o_queued_3 !== 3'd0) $display("FAIL midrst_queued: got %0d required 0", o_queued_3); else pass_cnt++;
      chk_cnt++; if (o_res_ready !== 1'b1) $display("FAIL midrst_ready: got %b required 1", o_res_ready); else pass_cnt++;
      chk_cnt++; if (o_data_42 !== 42'd0) $display("FAIL midrst_data: got %h required 0", o_data_42); else pass_cnt++;
      exp_q.delete();
      tb_cnt = 3'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      ack_delay = 5;
      ack_hold = 1'b0;
      rst = 1'b1;
      n0 = tog_cyc.size();
      repeat (10) @(posedge clk);
      #2;
      chk_cnt++;
      if (tog_cyc.size() != n0 || o_drive !== 1'b0)
         $display("FAIL midrst_quiet: sends=%0d drive=%b required %0d/0", tog_cyc.size(), o_drive, n0);
      else pass_cnt++;
      send_res(1'b1, 1'b0, 3'd0, 32'h0000_00fc, acc);
      @(posedge clk);
      #2;
      chk_cnt++;
      if (tog_cyc.size() != n0 + 1 || o_data_42 !== {1'b1, 8'h01, 3'd0, 30'h0000_003f})
         $display("FAIL midrst_resend: sends=%0d data=%h required %0d/%h", tog_cyc.size(), o_data_42, n0 + 1, {1'b1, 8'h01, 3'd0, 30'h0000_003f});
      else pass_cnt++;
      wait_drain();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b0;
      i_res_valid = 1'b0;
      i_res_mispredict = 1'b0;
      i_res_flush = 1'b0;
      i_res_slot_3 = 3'd0;
      i_res_correctPc_32 = 32'd0;
      test_reset();
      test_counter();
      test_flush();
      test_handshake();
      test_full();
      test_priority();
      test_back_to_back();
      test_reset_mid();
      chk_cnt++;
      if (exp_q.size() != 0) $display("FAIL sb_leftover: %0d messages never sent, required 0", exp_q.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
